// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Brief    : Shared encodings and width helper for the trace capture buffer.
//  Revision : 1.0  initial release
// ============================================================================
package trace_pkg;

  // Capture FSM states; the encoding is visible on the status port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Capture modes; the fourth encoding is reserved and treated as wrap.
  localparam logic [1:0] MODE_WRAP = 2'd0;
  localparam logic [1:0] MODE_STOP = 2'd1;
  localparam logic [1:0] MODE_TRIG = 2'd2;

  // Width of one stored entry: {pc, instr, watch channels}.
  function automatic int entry_w(input int xlen, input int num_watch);
    return xlen + 32 + num_watch * xlen;
  endfunction

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
//  Module   : trace_ram
//  Brief    : DEPTH x WIDTH entry storage, synchronous write, async read.
//  Revision : 1.0  initial release
// ============================================================================
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Contents are never reset; readers only look at entries they wrote.
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Show-ahead read: data follows the address with no clock latency.
  assign o_rdata = r_mem[i_raddr];

endmodule : trace_ram
`default_nettype wire

// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture_buffer
//  Brief    : Instruction/register trace capture with wrap, stop-on-full and
//             PC-trigger modes, drained through a valid/ready readout port.
//  Revision : 1.0  initial release
// ============================================================================
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int NUM_WATCH = 6,
  parameter int POST_TRIG = 8,
  localparam int ENTRY_W  = entry_w(XLEN, NUM_WATCH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cap_en,
  input  logic                      arm,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [XLEN-1:0]           pc_in,
  input  logic [31:0]               instr_in,
  input  logic [NUM_WATCH*XLEN-1:0] watch_in,
  input  logic [XLEN-1:0]           trig_pc,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [ENTRY_W-1:0]        rd_data,
  output logic [1:0]                state,
  output logic [CNT_W-1:0]          count,
  output logic                      overflow,
  output logic                      triggered
);

  localparam int AW = $clog2(DEPTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_post_cnt;
  logic             r_overflow;
  logic             r_triggered;
  logic [1:0]       r_mode;

  logic             w_active;
  logic             w_wr;
  logic             w_full;
  logic             w_trig_hit;
  logic             w_rd_valid;
  logic             w_pop;
  logic [ENTRY_W-1:0] w_rdata;

  // Entry storage; arm discards any write in the same cycle since the
  // pointers are being cleared anyway.
  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clock),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata ({pc_in, instr_in, watch_in}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Per-cycle event decode and next-state selection (arm has top priority).
  always_comb begin
    w_active     = (r_state == ST_CAPTURE) || (r_state == ST_POST);
    w_wr         = w_active && cap_en && !arm;
    w_full       = (r_count == CNT_W'(DEPTH));
    w_trig_hit   = w_wr && (r_state == ST_CAPTURE) && (r_mode == MODE_TRIG) &&
                   (pc_in == trig_pc);
    w_rd_valid   = (r_state == ST_DONE) && (r_count != '0);
    w_pop        = w_rd_valid && rd_ready && !arm;
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (arm) w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (arm)
          w_next_state = ST_CAPTURE;
        else if (stop)
          w_next_state = ST_DONE;
        else if (w_wr && (r_mode == MODE_STOP) && (r_count == CNT_W'(DEPTH - 1)))
          w_next_state = ST_DONE;
        else if (w_trig_hit)
          w_next_state = (POST_TRIG == 0) ? ST_DONE : ST_POST;
      end
      ST_POST: begin
        if (arm)
          w_next_state = ST_CAPTURE;
        else if (stop)
          w_next_state = ST_DONE;
        else if (w_wr && (r_post_cnt == CNT_W'(1)))
          w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (arm)
          w_next_state = ST_CAPTURE;
        else if (w_pop && (r_count == CNT_W'(1)))
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Pointers, occupancy, post-trigger countdown and sticky status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_post_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_triggered <= 1'b0;
      r_mode      <= MODE_WRAP;
    end else if (arm) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_post_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_triggered <= 1'b0;
      r_mode      <= mode;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        // A write into a full buffer evicts the oldest entry.
        if (w_full) begin
          r_rd_ptr   <= r_rd_ptr + AW'(1);
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
      if (w_trig_hit) begin
        r_triggered <= 1'b1;
        r_post_cnt  <= CNT_W'(POST_TRIG);
      end else if (w_wr && (r_state == ST_POST)) begin
        r_post_cnt <= r_post_cnt - CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count  <= r_count - CNT_W'(1);
      end
    end
  end

  assign rd_valid  = w_rd_valid;
  assign rd_data   = w_rdata;
  assign state     = r_state;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign triggered = r_triggered;

endmodule : trace_capture_buffer
`default_nettype wire

// File: tb/tb_trace_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_capture_buffer
//  Brief    : Self-checking bench: queue-based reference model compared every
//             cycle, directed scenarios with literal expectations, then
//             randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trace_capture_buffer;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 16;
  localparam int NUM_WATCH = 6;
  localparam int POST_TRIG = 8;
  localparam int EW        = XLEN + 32 + NUM_WATCH * XLEN;
  localparam int CW        = $clog2(DEPTH + 1);

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      cap_en;
  logic                      arm;
  logic                      stop;
  logic [1:0]                mode;
  logic [XLEN-1:0]           pc_in;
  logic [31:0]               instr_in;
  logic [NUM_WATCH*XLEN-1:0] watch_in;
  logic [XLEN-1:0]           trig_pc;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [EW-1:0]             rd_data;
  logic [1:0]                state;
  logic [CW-1:0]             count;
  logic                      overflow;
  logic                      triggered;

  always #5 clock = ~clock;

  trace_capture_buffer #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .NUM_WATCH (NUM_WATCH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cap_en    (cap_en),
    .arm       (arm),
    .stop      (stop),
    .mode      (mode),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .watch_in  (watch_in),
    .trig_pc   (trig_pc),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .state     (state),
    .count     (count),
    .overflow  (overflow),
    .triggered (triggered)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is a plain queue of entries, oldest first.
  logic [EW-1:0] mq[$];
  int            m_state = 0;
  int            m_mode  = 0;
  int            m_post  = 0;
  bit            m_ov    = 1'b0;
  bit            m_trig  = 1'b0;
  bit            cmp_en  = 1'b0;
  int            exp_pc[$];

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic [EW-1:0] e;
    int            nxt;
    e = {pc_in, instr_in, watch_in};
    if (reset) begin
      m_state = 0; mq.delete(); m_ov = 0; m_trig = 0; m_post = 0;
    end else if (arm) begin
      m_state = 1; mq.delete(); m_ov = 0; m_trig = 0; m_post = 0; m_mode = int'(mode);
    end else if (m_state == 1 || m_state == 2) begin
      nxt = m_state;
      if (cap_en) begin
        mq.push_back(e);
        if (mq.size() > DEPTH) begin
          void'(mq.pop_front());
          m_ov = 1;
        end
        if (m_state == 1 && m_mode == 1 && mq.size() == DEPTH) nxt = 3;
        if (m_state == 1 && m_mode == 2 && pc_in == trig_pc) begin
          m_trig = 1; m_post = POST_TRIG; nxt = 2;
        end
        if (m_state == 2) begin
          m_post--;
          if (m_post == 0) nxt = 3;
        end
      end
      if (stop) nxt = 3;
      m_state = nxt;
    end else if (m_state == 3) begin
      if (mq.size() != 0 && rd_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_state = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic rand_payload();
    instr_in = $urandom;
    for (int k = 0; k < NUM_WATCH; k++) watch_in[k*XLEN +: XLEN] = $urandom;
  endtask

  task automatic write_pc(input int pc);
    cap_en = 1'b1;
    pc_in  = pc;
    rand_payload();
    tick();
    cap_en = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] m);
    mode = m; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drain the buffer, checking the pc of each shown entry against exp_pc.
  task automatic read_all(input bit toggle);
    int got;
    bit rdy;
    got = 0;
    rdy = 1'b1;
    for (int cyc = 0; cyc < 100 && got < exp_pc.size(); cyc++) begin
      rd_ready = toggle ? rdy : 1'b1;
      if (rd_valid) begin
        chk("rd_pc", rd_data[EW-1 -: XLEN], exp_pc[got]);
        if (rd_ready) got++;
      end
      tick();
      rdy = ~rdy;
    end
    rd_ready = 1'b0;
    chk("rd_drained", got, exp_pc.size());
    chk("rd_idle_state", state, 0);
  endtask

  // Every-cycle comparison of all status/readout outputs against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("state", state, m_state);
      chk("count", count, mq.size());
      chk("overflow", overflow, m_ov);
      chk("triggered", triggered, m_trig);
      chk("rd_valid", rd_valid, (m_state == 3 && mq.size() != 0));
      if (m_state == 3 && mq.size() != 0) chk("rd_data", rd_data, mq[0]);
    end
  end

  initial begin
    reset = 1'b1; cap_en = 1'b0; arm = 1'b0; stop = 1'b0; mode = 2'd0;
    pc_in = '0; instr_in = '0; watch_in = '0; trig_pc = '0; rd_ready = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_state", state, 0);
    chk("reset_count", count, 0);
    chk("reset_rd_valid", rd_valid, 0);

    // Stop-on-full: DONE after the 16th write, later cap_en ignored.
    do_arm(2'd1);
    chk("s1_state_capture", state, 1);
    for (int i = 0; i < 20; i++) begin
      write_pc(4 * i);
      if (i == 15) chk("s1_done_at_16", state, 3);
    end
    chk("s1_count", count, 16);
    chk("s1_overflow", overflow, 0);
    exp_pc.delete();
    for (int i = 0; i < 16; i++) exp_pc.push_back(4 * i);
    read_all(1'b0);

    // Wrap: 20 writes then stop keeps the newest 16.
    do_arm(2'd0);
    for (int i = 0; i < 20; i++) write_pc(4 * i);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("s2_state", state, 3);
    chk("s2_count", count, 16);
    chk("s2_overflow", overflow, 1);
    exp_pc.delete();
    for (int i = 0; i < 16; i++) exp_pc.push_back(16 + 4 * i);
    read_all(1'b0);

    // Trigger at pc 40, eight post samples, readout with toggling ready.
    begin
      int last;
      last = -1;
      trig_pc = 40;
      do_arm(2'd2);
      for (int i = 0; i < 40 && state != 2'd3; i++) begin
        write_pc(4 * i);
        last = 4 * i;
      end
      chk("s3_last_pc", last, 72);
      chk("s3_triggered", triggered, 1);
      chk("s3_count", count, 16);
      exp_pc.delete();
      for (int i = 0; i < 16; i++) exp_pc.push_back(12 + 4 * i);
      chk("s3_index7_pc", exp_pc[7], 40);
      read_all(1'b1);
    end

    // Reset mid-POST with ten entries, while arm/stop/cap_en are also high.
    trig_pc = 20;
    do_arm(2'd2);
    for (int i = 0; i < 10; i++) write_pc(4 * i);
    chk("s5_state_post", state, 2);
    chk("s5_count", count, 10);
    reset = 1'b1; arm = 1'b1; stop = 1'b1; cap_en = 1'b1;
    tick();
    reset = 1'b0; arm = 1'b0; stop = 1'b0; cap_en = 1'b0;
    chk("s5_rst_state", state, 0);
    chk("s5_rst_count", count, 0);
    chk("s5_rst_rd_valid", rd_valid, 0);
    chk("s5_rst_triggered", triggered, 0);

    // Stop together with a write keeps that write.
    do_arm(2'd0);
    write_pc(0); write_pc(4); write_pc(8);
    stop = 1'b1;
    write_pc(100);
    stop = 1'b0;
    chk("s6_state", state, 3);
    chk("s6_count", count, 4);
    exp_pc.delete();
    exp_pc.push_back(0); exp_pc.push_back(4); exp_pc.push_back(8); exp_pc.push_back(100);
    read_all(1'b0);

    // Arm and stop together restart capture.
    do_arm(2'd0);
    write_pc(0); write_pc(4);
    arm = 1'b1; stop = 1'b1;
    tick();
    arm = 1'b0; stop = 1'b0;
    chk("s6_arm_stop_state", state, 1);
    chk("s6_arm_stop_count", count, 0);

    // Randomized traffic checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      arm      = ($urandom_range(0, 99) < 3);
      stop     = ($urandom_range(0, 99) < 3);
      cap_en   = ($urandom_range(0, 99) < 70);
      rd_ready = ($urandom_range(0, 1) == 1);
      mode     = 2'($urandom_range(0, 3));
      pc_in    = $urandom_range(0, 15) * 4;
      if ($urandom_range(0, 19) == 0) trig_pc = $urandom_range(0, 15) * 4;
      rand_payload();
      tick();
    end
    reset = 1'b0; arm = 1'b0; stop = 1'b0; cap_en = 1'b0; rd_ready = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_trace_capture_buffer
`default_nettype wire

// File: doc/trace_capture_buffer.md
TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the PC and watched-register width.
REQ-002 The module SHALL have parameter DEPTH, default 16, giving the entry count; it SHALL be a power of two and at least 4.
REQ-003 The module SHALL have parameter NUM_WATCH, default 6, giving the number of watched register channels.
REQ-004 The module SHALL have parameter POST_TRIG, default 8, giving the samples kept after a trigger; it SHALL be less than DEPTH.
REQ-005 The module SHALL have one clock, port clock (input, 1), with all state updated on its rising edge.
REQ-006 The module SHALL have port reset (input, 1), a synchronous, active-high reset.
REQ-007 The module SHALL have these control inputs: cap_en (1), sample this cycle; arm (1), start a capture; stop (1), force end of capture; mode (2), capture mode.
REQ-008 The module SHALL have these sample inputs: pc_in (XLEN), instr_in (32), watch_in (NUM_WATCH*XLEN, channel k at bits [k*XLEN +: XLEN]), and trig_pc (XLEN).
REQ-009 The module SHALL have these readout ports: rd_valid (output, 1), rd_ready (input, 1), and rd_data (output, ENTRY_W = XLEN+32+NUM_WATCH*XLEN, packed {pc, instr, watch}).
REQ-010 The module SHALL have these status outputs: state (2), count (clog2(DEPTH+1)), overflow (1), and triggered (1).

Function
REQ-011 The block SHALL implement an FSM with states IDLE=0, CAPTURE=1, POST=2, DONE=3.
REQ-012 In IDLE, arm SHALL clear the pointers, count, overflow and triggered, latch mode, and move to CAPTURE the next cycle.
REQ-013 In CAPTURE or POST, an entry SHALL be written when cap_en=1 and SHALL be readable from the next cycle.
REQ-014 In mode 0 (wrap), writing when full SHALL overwrite the oldest entry, advance the read pointer, hold count at DEPTH, and set overflow sticky.
REQ-015 In mode 1 (stop-on-full), the write that makes count==DEPTH SHALL move the FSM to DONE, and no further writes SHALL occur.
REQ-016 In mode 2 (trigger), the block SHALL wrap as in mode 0.
REQ-017 In mode 2, the write with pc_in==trig_pc SHALL set triggered, load the post counter with POST_TRIG, and move the FSM to POST.
REQ-018 In POST, each write SHALL decrement the post counter, and the write that takes it to 0 SHALL move the FSM to DONE.
REQ-019 Mode 3 is reserved and SHALL behave as mode 0.
REQ-020 In CAPTURE or POST, stop=1 SHALL move the FSM to DONE; a cap_en write in the same cycle SHALL still be stored.
REQ-021 In CAPTURE or POST, arm=1 SHALL restart as in REQ-012 and take priority over stop and over a trigger.
REQ-022 In DONE, rd_valid SHALL equal (count!=0), and rd_data SHALL be the oldest entry, combinationally from the read pointer (show-ahead).
REQ-023 In DONE, each cycle with rd_valid and rd_ready both high SHALL pop one entry, oldest first.
REQ-024 The pop that takes count to 0 SHALL return the FSM to IDLE.
REQ-025 In DONE, arm=1 SHALL discard the remaining entries and restart capture.
REQ-026 rd_valid SHALL be 0 in every state other than DONE, and cap_en SHALL be ignored in IDLE and DONE.
REQ-027 Pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-028 The trigger compare SHALL use the full XLEN bits, unsigned equality.

Reset
REQ-029 When reset=1 at a rising edge, the block SHALL set state=IDLE, count=0, overflow=0, triggered=0, rd_valid=0, the pointers to 0, and the post counter to 0.
REQ-030 Reset SHALL override arm, stop and cap_en in the same cycle.
REQ-031 Entry storage contents SHALL NOT be reset, and rd_data SHALL be don't-care while rd_valid=0.

Structure
REQ-032 Package trace_pkg SHALL hold the state encodings, the mode encodings (MODE_WRAP=0, MODE_STOP=1, MODE_TRIG=2), and the ENTRY_W width function.
REQ-033 The entry storage SHALL be a sub-module trace_ram with DEPTH x ENTRY_W, one synchronous write port, one asynchronous read port, and no reset.
REQ-034 The FSM, pointers, count and post counter SHALL reside in trace_capture_buffer.

Verification
REQ-035 Scenario 1: DEPTH=16, mode 1, arm, then 20 cap_en cycles with pc_in=0,4,...,76 -> DONE after the 16th write; readout gives pc 0..60 in order; overflow=0.
REQ-036 Scenario 2: mode 0, 20 writes with pc 0..76, then stop -> count=16, overflow=1; readout gives pc 16..76.
REQ-037 Scenario 3: mode 2, trig_pc=40, POST_TRIG=8, pc stepping by 4 from 0 -> DONE after the pc=72 write; triggered=1; readout gives pc 12..72 (16 entries), with pc=40 at index 7.
REQ-038 Scenario 4: readout with rd_ready toggling 1,0,1,0 -> a pop occurs only on handshake cycles; rd_data stays stable while rd_ready=0; the FSM reaches IDLE on the final pop.
REQ-039 Scenario 5: reset asserted mid-POST with count=10 -> next cycle state=0, count=0, rd_valid=0, triggered=0.
REQ-040 Scenario 6: stop and cap_en in the same cycle with pc=100 -> the last readout entry has pc=100; arm and stop in the same cycle -> state=CAPTURE, count=0.
